vga_frame_reader: RTL and testbench

- Display-side stage directly downstream of the nearest-neighbour scaler.
- Generates 640x480@60 VGA timing and fetches the scaled frame from the shared frame buffer, which the scaler writes linearly at row-major addresses with stride W.
- Centres the image on screen for the active zoom level and drives gray-level RGB, with background colour outside the image window.
- Latches zoom level and image validity only at frame boundaries, so there is no tearing.

---
 rtl/vga_frame_reader.sv | 195 +++++++++++++++++++
 tb/tb_vga_frame_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator that fetches the scaled image from the frame buffer
// and centres it on screen. Zoom and image validity are latched only at frame boundaries.
module vga_frame_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned RD_LATENCY = 1,
    parameter logic [7:0]  BG_COLOR   = 8'h00,
    parameter int unsigned BASE_W     = 160,
    parameter int unsigned BASE_H     = 120
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  zoom_level,
    input  logic        img_done,
    input  logic [7:0]  fb_rd_data,
    output logic [18:0] fb_rd_addr,
    output logic        fb_rd_en,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [9:0] W_S = 10'(BASE_W);
    localparam logic [9:0] H_S = 10'(BASE_H);
    localparam logic [9:0] W_M = 10'(2 * BASE_W);
    localparam logic [9:0] H_M = 10'(2 * BASE_H);
    localparam logic [9:0] W_L = 10'(4 * BASE_W);
    localparam logic [9:0] H_L = 10'(4 * BASE_H);
    localparam logic [9:0] X_S = 10'((H_ACTIVE - BASE_W) / 2);
    localparam logic [9:0] Y_S = 10'((V_ACTIVE - BASE_H) / 2);
    localparam logic [9:0] X_M = 10'((H_ACTIVE - 2 * BASE_W) / 2);
    localparam logic [9:0] Y_M = 10'((V_ACTIVE - 2 * BASE_H) / 2);
    localparam logic [9:0] X_L = 10'((H_ACTIVE - 4 * BASE_W) / 2);
    localparam logic [9:0] Y_L = 10'((V_ACTIVE - 4 * BASE_H) / 2);

    typedef enum logic [1:0] {
        ZOOM_160 = 2'd0,
        ZOOM_320 = 2'd1,
        ZOOM_640 = 2'd2
    } zoom_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic act;
        logic win;
    } flags_t;

    // Sync stages idle high so no false sync pulse leaves the pipe after reset.
    localparam flags_t FLAGS_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, win: 1'b0};

    function automatic zoom_t decode_zoom(input logic [2:0] z);
        case (z)
            3'd3:    return ZOOM_320;
            3'd4:    return ZOOM_640;
            default: return ZOOM_160;
        endcase
    endfunction

    function automatic logic window_hit(input logic [9:0] h, input logic [9:0] v, input zoom_t z);
        logic [9:0] x0, y0, w, ht;
        case (z)
            ZOOM_320: begin x0 = X_M; y0 = Y_M; w = W_M; ht = H_M; end
            ZOOM_640: begin x0 = X_L; y0 = Y_L; w = W_L; ht = H_L; end
            default:  begin x0 = X_S; y0 = Y_S; w = W_S; ht = H_S; end
        endcase
        return (h >= x0) && (h < x0 + w) && (v >= y0) && (v < y0 + ht);
    endfunction

    logic [9:0]  h_cnt, v_cnt, h_nxt, v_nxt;
    logic        h_wrap, v_wrap, frame_wrap;
    zoom_t       zoom_active, zoom_nxt;
    logic        img_pending, img_show, pending_nxt, show_nxt;
    logic [2:0]  zoom_prev;
    logic        in_win, en_nxt;
    logic [18:0] addr_nxt;
    flags_t      cur_flags;
    flags_t      pipe [RD_LATENCY];
    logic [7:0]  pix;

    always_comb begin
        h_wrap      = (h_cnt == H_LAST);
        v_wrap      = (v_cnt == V_LAST);
        frame_wrap  = h_wrap && v_wrap;
        h_nxt       = h_wrap ? '0 : h_cnt + 10'd1;
        v_nxt       = v_cnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : v_cnt + 10'd1;
        end
        zoom_nxt    = frame_wrap ? decode_zoom(zoom_level) : zoom_active;
        show_nxt    = frame_wrap ? img_pending : img_show;
        in_win      = window_hit(h_cnt, v_cnt, zoom_active);

        // The address register tracks the current counters, so the strobe is
        // pre-computed from the next counter position to stay aligned with it.
        addr_nxt = fb_rd_addr;
        if (frame_wrap) begin
            addr_nxt = '0;
        end else if (in_win) begin
            addr_nxt = fb_rd_addr + 19'd1;
        end
        en_nxt = window_hit(h_nxt, v_nxt, zoom_nxt) && show_nxt;

        pending_nxt = img_pending;
        if (zoom_level != zoom_prev) begin
            pending_nxt = 1'b0;
        end else if (img_done) begin
            pending_nxt = 1'b1;
        end

        cur_flags.hs  = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        cur_flags.vs  = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        cur_flags.act = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        cur_flags.win = in_win && img_show;

        pix = '0;
        if (pipe[RD_LATENCY-1].win) begin
            pix = fb_rd_data;
        end else if (pipe[RD_LATENCY-1].act) begin
            pix = BG_COLOR;
        end

        frame_start = (h_cnt == '0) && (v_cnt == '0) && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            fb_rd_addr  <= '0;
            fb_rd_en    <= 1'b0;
            zoom_active <= ZOOM_160;
            img_pending <= 1'b0;
            img_show    <= 1'b0;
            zoom_prev   <= '0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            fb_rd_addr  <= addr_nxt;
            fb_rd_en    <= en_nxt;
            zoom_active <= zoom_nxt;
            img_pending <= pending_nxt;
            img_show    <= show_nxt;
            zoom_prev   <= zoom_level;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe[i] <= FLAGS_IDLE;
            end
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
        end else begin
            pipe[0] <= cur_flags;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
            vga_hs      <= pipe[RD_LATENCY-1].hs;
            vga_vs      <= pipe[RD_LATENCY-1].vs;
            vga_blank_n <= pipe[RD_LATENCY-1].act;
            vga_r       <= pix;
            vga_g       <= pix;
            vga_b       <= pix;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader on a reduced screen geometry, two read latencies side by side.
module tb_vga_frame_reader;

    localparam int HA = 32, HF = 2, HSW = 4, HB = 2;
    localparam int VA = 24, VF = 1, VSW = 2, VB = 1;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam int BW = 8, BH = 6;
    localparam logic [7:0] BG = 8'h3C;
    localparam logic [10:0] RST_E = {1'b1, 1'b1, 1'b0, 8'h00};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic [2:0] zoom_level = 3'd0;
    logic       img_done = 1'b0;

    logic [18:0] addr1, addr3;
    logic        en1, en3, hs1, hs3, vs1, vs3, bn1, bn3, fs1, fs3;
    logic [7:0]  data1, data3, r1, g1, b1, r3, g3, b3;

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .RD_LATENCY(1), .BG_COLOR(BG), .BASE_W(BW), .BASE_H(BH)
    ) dut1 (
        .clk(clk), .reset(reset), .zoom_level(zoom_level), .img_done(img_done),
        .fb_rd_data(data1), .fb_rd_addr(addr1), .fb_rd_en(en1),
        .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1),
        .vga_blank_n(bn1), .frame_start(fs1)
    );

    vga_frame_reader #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .RD_LATENCY(3), .BG_COLOR(BG), .BASE_W(BW), .BASE_H(BH)
    ) dut3 (
        .clk(clk), .reset(reset), .zoom_level(zoom_level), .img_done(img_done),
        .fb_rd_data(data3), .fb_rd_addr(addr3), .fb_rd_en(en3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hs(hs3), .vga_vs(vs3),
        .vga_blank_n(bn3), .frame_start(fs3)
    );

    // Frame-buffer models: data is the low address byte, RD_LATENCY cycles later.
    logic [18:0] ram1;
    logic [18:0] ram3 [3];
    always @(posedge clk) begin
        ram1    <= addr1;
        ram3[0] <= addr3;
        ram3[1] <= ram3[0];
        ram3[2] <= ram3[1];
    end
    assign data1 = ram1[7:0];
    assign data3 = ram3[2][7:0];

    typedef struct {
        logic [2:0] zoom;
        bit         done;
        bit         sim;
        int         exp_cnt;
        int         exp_last;
        int         exp_x0;
        int         exp_y0;
    } vec_t;
    vec_t tab [6];

    int total = 0, bad = 0;
    int mh = 0, mv = 0, mz = 0;
    bit mshow = 0, mpend = 0;
    logic [2:0] mzprev = 3'd0;
    logic [10:0] q1 [$];
    logic [10:0] q3 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [26:0] expand(input logic [10:0] e);
        return {e[10:8], e[7:0], e[7:0], e[7:0]};
    endfunction

    function automatic int dz(input logic [2:0] z);
        if (z == 3'd3) return 1;
        if (z == 3'd4) return 2;
        return 0;
    endfunction

    task automatic reset_model();
        mh = 0; mv = 0; mz = 0; mshow = 0; mpend = 0; mzprev = 3'd0;
        q1.delete();
        q3.delete();
        for (int i = 0; i < 2; i++) q1.push_back(RST_E);
        for (int i = 0; i < 4; i++) q3.push_back(RST_E);
    endtask

    initial begin : monitor
        int w, h, x0, y0, ea, sc;
        bit inw, ewin, act, ehs, evs, wrap;
        logic [7:0] ergb;
        logic [10:0] e;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_out1", {hs1, vs1, bn1, r1, g1, b1}, expand(RST_E));
                check("rst_out3", {hs3, vs3, bn3, r3, g3, b3}, expand(RST_E));
                check("rst_rd1", {fs1, en1, addr1}, 0);
                check("rst_rd3", {fs3, en3, addr3}, 0);
                reset_model();
            end else begin
                sc = (mz == 2) ? 4 : (mz == 1) ? 2 : 1;
                w  = BW * sc;
                h  = BH * sc;
                x0 = (HA - w) / 2;
                y0 = (VA - h) / 2;
                inw  = (mh >= x0) && (mh < x0 + w) && (mv >= y0) && (mv < y0 + h);
                ea   = (mv - y0) * w + (mh - x0);
                ewin = inw && mshow;
                act  = (mh < HA) && (mv < VA);
                ehs  = !((mh >= HA + HF) && (mh < HA + HF + HSW));
                evs  = !((mv >= VA + VF) && (mv < VA + VF + VSW));
                ergb = ewin ? 8'(ea) : (act ? BG : 8'h00);

                check("rd_en1", en1, ewin);
                check("rd_en3", en3, ewin);
                if (inw) begin
                    check("rd_addr1", addr1, ea);
                    check("rd_addr3", addr3, ea);
                end
                check("frame_start1", fs1, (mh == 0) && (mv == 0));
                check("frame_start3", fs3, (mh == 0) && (mv == 0));

                e = q1.pop_front();
                check("out_lat1", {hs1, vs1, bn1, r1, g1, b1}, expand(e));
                e = q3.pop_front();
                check("out_lat3", {hs3, vs3, bn3, r3, g3, b3}, expand(e));
                q1.push_back({ehs, evs, act, ergb});
                q3.push_back({ehs, evs, act, ergb});

                wrap = (mh == HT - 1) && (mv == VT - 1);
                if (wrap) begin
                    mz    = dz(zoom_level);
                    mshow = mpend;
                end
                if (zoom_level != mzprev) mpend = 0;
                else if (img_done) mpend = 1;
                mzprev = zoom_level;
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        check("wait_pos", (mh == h && mv == v), 1);
    endtask

    task automatic count_frame(input int zoom_v, input logic [2:0] new_zoom, input int done_v,
                               output int c1, output int c3, output int last,
                               output int fh, output int fv, output int faddr);
        c1 = 0; c3 = 0; last = -1; fh = -1; fv = -1; faddr = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (en1) begin
                if (c1 == 0) begin fh = mh; fv = mv; faddr = int'(addr1); end
                c1++;
                last = int'(addr1);
            end
            if (en3) c3++;
            if (mh == 0 && mv == zoom_v) zoom_level = new_zoom;
            img_done = (mh == 0 && mv == done_v);
            tick();
        end
        img_done = 1'b0;
    endtask

    initial begin : watchdog
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, hl, vl, c1, c3, last, fh, fv, fa;
        tab[0] = '{3'd2, 1'b1, 1'b0,  48,  47, 12, 9};
        tab[1] = '{3'd3, 1'b1, 1'b0, 192, 191,  8, 6};
        tab[2] = '{3'd4, 1'b1, 1'b0, 768, 767,  0, 0};
        tab[3] = '{3'd0, 1'b0, 1'b0,   0,   0,  0, 0};
        tab[4] = '{3'd7, 1'b1, 1'b1,   0,   0,  0, 0};
        tab[5] = '{3'd7, 1'b1, 1'b0,  48,  47, 12, 9};

        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("fs_first1", fs1, 1);
        check("fs_first3", fs3, 1);

        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin tick(); n++; end while (!fs1 && n < 2 * FRAME);
            check($sformatf("fs_period%0d", k), n, FRAME);
        end
        hl = 0; vl = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (!hs1) hl++;
            if (!vs3) vl++;
            tick();
        end
        check("hs_low_cnt", hl, HSW * VT);
        check("vs_low_cnt", vl, VSW * HT);

        for (int k = 0; k < 6; k++) begin
            wait_pos(0, 2);
            zoom_level = tab[k].zoom;
            img_done   = tab[k].sim;
            tick();
            img_done = 1'b0;
            if (tab[k].done && !tab[k].sim) begin
                img_done = 1'b1;
                tick();
                img_done = 1'b0;
            end
            wait_pos(0, 0);
            count_frame(-1, 3'd0, -1, c1, c3, last, fh, fv, fa);
            check($sformatf("v%0d_strobes1", k), c1, tab[k].exp_cnt);
            check($sformatf("v%0d_strobes3", k), c3, tab[k].exp_cnt);
            if (tab[k].exp_cnt > 0) begin
                check($sformatf("v%0d_last_addr", k), last, tab[k].exp_last);
                check($sformatf("v%0d_first_h", k), fh, tab[k].exp_x0);
                check($sformatf("v%0d_first_v", k), fv, tab[k].exp_y0);
                check($sformatf("v%0d_first_addr", k), fa, 0);
            end
        end

        // Zoom 3 -> 4 mid-frame with a fresh image later in the same frame.
        wait_pos(0, 2);
        zoom_level = 3'd3;
        tick();
        img_done = 1'b1;
        tick();
        img_done = 1'b0;
        wait_pos(0, 0);
        count_frame(10, 3'd4, 15, c1, c3, last, fh, fv, fa);
        check("midzoom_cur_cnt", c1, 192);
        check("midzoom_cur_last", last, 191);
        check("midzoom_cur_first_h", fh, 8);
        count_frame(-1, 3'd0, -1, c1, c3, last, fh, fv, fa);
        check("midzoom_next_cnt", c1, 768);
        check("midzoom_next_cnt3", c3, 768);
        check("midzoom_next_last", last, 767);

        // Asynchronous reset in the middle of a line.
        wait_pos(20, 15);
        reset = 1'b1;
        #1;
        check("async_rst_out1", {hs1, vs1, bn1, r1, g1, b1}, expand(RST_E));
        check("async_rst_out3", {hs3, vs3, bn3, r3, g3, b3}, expand(RST_E));
        check("async_rst_rd1", {fs1, en1, addr1}, 0);
        check("async_rst_rd3", {fs3, en3, addr3}, 0);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check("post_rst_fs1", fs1, 1);
        check("post_rst_fs3", fs3, 1);
        for (int k = 0; k < 2; k++) begin
            count_frame(-1, 3'd0, -1, c1, c3, last, fh, fv, fa);
            check($sformatf("post_rst_noshow%0d", k), c1 + c3, 0);
        end
        wait_pos(0, 2);
        img_done = 1'b1;
        tick();
        img_done = 1'b0;
        wait_pos(0, 0);
        count_frame(-1, 3'd0, -1, c1, c3, last, fh, fv, fa);
        check("post_rst_show_cnt", c1, 768);
        check("post_rst_show_last", last, 767);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
